// File: rtl/response_dumper.sv
// Response-memory dumper: after file_finished, streams a count header and then
// every response word in address order over valid/ready, flagging the last byte.
module response_dumper #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              file_finished,
  input  logic [ADDR_W-1:0] resp_count,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_RD, S_WAIT, S_OUT, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              mem_rd_q, mem_rd_d;
  logic              data_last;

  // Extra bit keeps addr+1 from wrapping when cnt is the maximum encodable count.
  assign data_last = ({1'b0, addr_q} + (ADDR_W+1)'(1)) == {1'b0, cnt_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: if (file_finished) begin
        cnt_d   = resp_count;
        addr_d  = '0;
        data_d  = DATA_W'(resp_count);
        state_d = S_HDR;
      end
      S_HDR:  if (out_ready) state_d = (cnt_q == '0) ? S_DONE : S_RD;
      S_RD:   state_d = S_WAIT;
      S_WAIT: begin
        data_d  = mem_data;
        state_d = S_OUT;
      end
      S_OUT:  if (out_ready) begin
        if (data_last) state_d = S_DONE;
        else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_RD;
        end
      end
      S_DONE: if (!file_finished) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read strobe and address are registered on entry to RD; address holds afterwards.
  assign mem_rd_d   = (state_d == S_RD);
  assign mem_addr_d = mem_rd_d ? addr_d : mem_addr_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign out_data  = data_q;
  assign out_valid = (state_q == S_HDR) || (state_q == S_OUT);
  assign out_last  = ((state_q == S_HDR) && (cnt_q == '0)) ||
                     ((state_q == S_OUT) && data_last);
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_response_dumper.sv
// Bench for response_dumper: a queue model of the expected byte stream
// (header count, then memory words) checked beat by beat at the sink.
module tb_response_dumper;

  logic       clock, reset, file_finished, out_ready;
  logic [7:0] resp_count, mem_addr, mem_data, out_data;
  logic       mem_rd, out_valid, out_last, busy, done;

  logic [7:0] mem [256];
  int tests = 0;
  int fails = 0;

  response_dumper #(.ADDR_W(8), .DATA_W(8)) dut (
    .clock(clock), .reset(reset), .file_finished(file_finished),
    .resp_count(resp_count), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered-read RAM
  always @(posedge clock) if (mem_rd) mem_data <= mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int n;        // resp_count
    int rdy;      // out_ready probability in percent
    int exp_hdr;  // expected header byte
    int exp_cyc;  // expected HDR-to-DONE cycles, -1 = not checked
  } vec_t;

  // Called at a negedge with the DUT idle. Expected stream is {hdr, mem[0..n-1]}.
  task automatic run_dump(input int n, input int rdy, input int exp_hdr, input int exp_cyc,
                          input int alt, input int stall_beat);
    logic [7:0] q[$];
    int rd_idx, cyc, popped, stall_left;
    bit prev_stall, fin;
    logic [7:0] pd;
    logic pl;
    rd_idx = 0; cyc = 0; popped = 0; stall_left = 5; prev_stall = 0; fin = 0;
    pd = '0; pl = 1'b0;
    q.push_back(8'(exp_hdr));
    for (int i = 0; i < n; i++) q.push_back(mem[i]);
    resp_count = 8'(n);
    file_finished = 1'b1;
    out_ready = 1'b0;
    @(negedge clock);
    check("start_valid", out_valid, 1);
    while (!fin && cyc < 5000) begin
      out_ready = ($urandom_range(99) < rdy);
      if (popped == stall_beat && out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end
      check("busy", busy, 1);
      if (mem_rd) begin
        check("mem_addr", mem_addr, rd_idx);
        rd_idx++;
      end
      if (!out_valid) check("last_low", out_last, 0);
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, pd);
        check("stall_last", out_last, pl);
      end
      prev_stall = 0;
      if (out_valid) begin
        if (out_ready) begin
          check("data", out_data, q[0]);
          check("last", out_last, q.size() == 1);
          void'(q.pop_front());
          popped++;
          if (alt >= 0 && popped == 1) resp_count = 8'(alt);
          if (q.size() == 0) fin = 1;
        end else begin
          prev_stall = 1;
          pd = out_data;
          pl = out_last;
        end
      end
      @(negedge clock);
      cyc++;
    end
    if (!fin) begin
      tests++; fails++;
      $display("FAIL timeout: %0d beats left after %0d cycles", q.size(), cyc);
    end
    out_ready = 1'b0;
    check("done", done, 1);
    check("busy_end", busy, 0);
    check("rd_count", rd_idx, n);
    if (exp_cyc >= 0) check("total_cycles", cyc, exp_cyc);
  endtask

  task automatic end_dump();
    file_finished = 1'b0;
    @(negedge clock);
    check("done_clear", done, 0);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{2,   100, 2,   7});
    vecs.push_back('{0,   100, 0,   1});
    vecs.push_back('{1,   100, 1,   4});
    vecs.push_back('{5,   50,  5,   -1});
    vecs.push_back('{255, 100, 255, 766});
    vecs.push_back('{17,  30,  17,  -1});

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h10; mem[1] = 8'h2A;
    mem_data = '0;
    reset = 1'b0; file_finished = 1'b0; out_ready = 1'b0; resp_count = '0;
    #13;
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    foreach (vecs[i]) begin
      run_dump(vecs[i].n, vecs[i].rdy, vecs[i].exp_hdr, vecs[i].exp_cyc, -1, -1);
      end_dump();
    end

    // Backpressure on data byte 1 for 5 cycles
    run_dump(4, 100, 4, -1, -1, 2);
    end_dump();

    // Count change after the header beat is ignored
    run_dump(3, 100, 3, 10, 7, -1);
    end_dump();

    // Reset during OUT of data byte 1, then restart with file_finished still high
    resp_count = 8'd4; file_finished = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    repeat (6) @(negedge clock);
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_data", out_data, mem[1]);
    out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_last", out_last, 0);
    check("abort_data", out_data, 0);
    check("abort_busy", busy, 0);
    check("abort_mem_rd", mem_rd, 0);
    check("abort_mem_addr", mem_addr, 0);
    @(negedge clock);
    reset = 1'b1;
    run_dump(4, 100, 4, 13, -1, -1);

    // Re-arm: no re-dump while file_finished stays high
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("hold_valid", out_valid, 0);
      check("hold_done", done, 1);
    end
    file_finished = 1'b0;
    @(negedge clock);
    run_dump(4, 100, 4, 13, -1, -1);
    end_dump();

    // Randomized dumps
    for (int k = 0; k < 8; k++) begin
      int n, r;
      n = $urandom_range(0, 40);
      r = $urandom_range(20, 100);
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      run_dump(n, r, n, (r == 100) ? 1 + 3 * n : -1, -1, -1);
      end_dump();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
